fp_add_pipe: RTL

FP_ADD_PIPE -- requirements
Module: fp_add_pipe

---
 rtl/fp_add_pipe.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: multi-cycle IEEE-754 adder/subtractor.
// It holds one operation at a time and steps it through ALIGN, ADD, NORM and OUT.
// Subnormal inputs are treated as zero, and results below the normal range are
// flushed to zero.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [3:0]           flags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 4;     // hidden + fraction + guard/round/sticky
    localparam int RW    = MAN_W + 2;     // rounded significand plus rounding carry
    localparam int EW2   = EXP_W + 2;     // signed exponent with headroom both ways
    localparam int LZW   = $clog2(SW + 1);
    localparam int SHMAX = MAN_W + 3;     // shifts this large keep only sticky

    localparam logic [EXP_W-1:0]      EXP_ONES = '1;
    localparam logic signed [EW2-1:0] E_ONE    = EW2'(1);
    localparam logic signed [EW2-1:0] E_MAX    = EW2'(EXP_ONES);
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;

    // Operands after swap and alignment: l = larger magnitude, s = smaller magnitude.
    typedef struct packed {
        logic             sign_l;
        logic             sign_s;
        logic [EXP_W-1:0] exp_l;
        logic [SW-1:0]    sig_l;
        logic [SW-1:0]    sig_s;
    } align_t;

    // NaN/infinity outcome, decided in ALIGN and carried to the output.
    typedef struct packed {
        logic         hit;
        logic [W-1:0] res;
        logic [3:0]   flg;
    } spec_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    align_t         aln_q, aln_d;
    spec_t          spc_q, spc_d;
    logic [SW:0]    sum_q, sum_d;
    logic           eff_sub_q, eff_sub_d;
    logic [W-1:0]   result_q, result_d;
    logic [3:0]     flags_q, flags_d;

    // ALIGN intermediates
    logic             sa, sb, nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, a_ge, lost;
    logic [EXP_W-1:0] exp_a, exp_b, exp_s, exp_diff;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic [MAN_W:0]   sig_a, sig_b, sig_sm;
    logic [W-2:0]     mag_a, mag_b;
    logic [SW-1:0]    ext_s, shifted;

    // NORM intermediates
    logic [LZW-1:0]         lzc;
    logic                   found, rnd_up, inexact;
    logic [SW-1:0]          norm;
    logic signed [EW2-1:0]  e_norm, e_rnd;
    logic [RW-1:0]          rnd;
    logic [MAN_W-1:0]       frac_r;
    logic [W-1:0]           res_n;
    logic [3:0]             flg_n;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign result    = result_q;
    assign flags     = flags_q;

    // Control sequence: fixed walk from ALIGN to OUT, then wait for the consumer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ALIGN;
            ALIGN:   state_d = ADD;
            ADD:     state_d = NORM;
            NORM:    state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture operands on accept; subtraction becomes addition of the negated b.
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        if (state_q == IDLE && in_valid) begin
            a_d = a;
            b_d = {b[W-1] ^ sub, b[W-2:0]};
        end
    end

    // ALIGN: classify, order by magnitude, and shift the smaller into GRS bits.
    always_comb begin
        sa     = a_q[W-1];
        sb     = b_q[W-1];
        exp_a  = a_q[W-2 -: EXP_W];
        exp_b  = b_q[W-2 -: EXP_W];
        frac_a = a_q[MAN_W-1:0];
        frac_b = b_q[MAN_W-1:0];
        nan_a  = (exp_a == EXP_ONES) && (frac_a != '0);
        nan_b  = (exp_b == EXP_ONES) && (frac_b != '0);
        snan_a = nan_a && !frac_a[MAN_W-1];
        snan_b = nan_b && !frac_b[MAN_W-1];
        inf_a  = (exp_a == EXP_ONES) && (frac_a == '0);
        inf_b  = (exp_b == EXP_ONES) && (frac_b == '0);
        // A zero exponent field (zero or subnormal) counts as zero.
        sig_a  = (exp_a == '0) ? '0 : {1'b1, frac_a};
        sig_b  = (exp_b == '0) ? '0 : {1'b1, frac_b};
        mag_a  = (exp_a == '0) ? '0 : a_q[W-2:0];
        mag_b  = (exp_b == '0) ? '0 : b_q[W-2:0];
        a_ge   = (mag_a >= mag_b);
        exp_s  = a_ge ? exp_b : exp_a;
        sig_sm = a_ge ? sig_b : sig_a;
        exp_diff = (a_ge ? exp_a : exp_b) - exp_s;
        ext_s   = {sig_sm, 3'b000};
        shifted = ext_s >> exp_diff;
        lost    = ((shifted << exp_diff) != ext_s);

        aln_d = aln_q;
        spc_d = spc_q;
        if (state_q == ALIGN) begin
            aln_d.sign_l = a_ge ? sa : sb;
            aln_d.sign_s = a_ge ? sb : sa;
            aln_d.exp_l  = a_ge ? exp_a : exp_b;
            aln_d.sig_l  = {(a_ge ? sig_a : sig_b), 3'b000};
            if (int'(exp_diff) >= SHMAX)
                aln_d.sig_s = SW'(|sig_sm);
            else
                aln_d.sig_s = shifted | SW'(lost);

            spc_d = '0;
            if (nan_a || nan_b) begin
                spc_d.hit = 1'b1;
                spc_d.res = QNAN;
                spc_d.flg = {snan_a | snan_b, 3'b000};
            end else if (inf_a && inf_b && (sa != sb)) begin
                spc_d.hit = 1'b1;
                spc_d.res = QNAN;
                spc_d.flg = 4'b1000;
            end else if (inf_a) begin
                spc_d.hit = 1'b1;
                spc_d.res = a_q;
            end else if (inf_b) begin
                spc_d.hit = 1'b1;
                spc_d.res = b_q;
            end
        end
    end

    // ADD: magnitude add or (larger - smaller) subtract with one carry bit.
    always_comb begin
        sum_d     = sum_q;
        eff_sub_d = eff_sub_q;
        if (state_q == ADD) begin
            eff_sub_d = aln_q.sign_l ^ aln_q.sign_s;
            if (eff_sub_d)
                sum_d = {1'b0, aln_q.sig_l} - {1'b0, aln_q.sig_s};
            else
                sum_d = {1'b0, aln_q.sig_l} + {1'b0, aln_q.sig_s};
        end
    end

    // NORM: normalise, round to nearest even, pick the final encoding and flags.
    always_comb begin
        lzc   = '0;
        found = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!found) begin
                if (sum_q[i]) found = 1'b1;
                else          lzc   = lzc + LZW'(1);
            end
        end

        if (sum_q[SW]) begin
            // Carry out: shift right one place and fold the dropped bit into sticky.
            norm   = {sum_q[SW:2], sum_q[1] | sum_q[0]};
            e_norm = EW2'(aln_q.exp_l) + E_ONE;
        end else begin
            norm   = sum_q[SW-1:0] << lzc;
            e_norm = EW2'(aln_q.exp_l) - EW2'(lzc);
        end

        rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
        inexact = |norm[2:0];
        rnd     = {1'b0, norm[SW-1:3]} + RW'(rnd_up);
        e_rnd   = rnd[RW-1] ? e_norm + E_ONE : e_norm;
        frac_r  = rnd[RW-1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

        res_n = {aln_q.sign_l, e_rnd[EXP_W-1:0], frac_r};
        flg_n = {3'b000, inexact};
        if (spc_q.hit) begin
            res_n = spc_q.res;
            flg_n = spc_q.flg;
        end else if (sum_q == '0) begin
            // Exact cancellation is +0; only like-signed zeros keep their sign.
            res_n = {aln_q.sign_l & ~eff_sub_q, {(W-1){1'b0}}};
            flg_n = 4'b0000;
        end else if (e_rnd < E_ONE) begin
            res_n = {aln_q.sign_l, {(W-1){1'b0}}};
            flg_n = 4'b0011;
        end else if (e_rnd >= E_MAX) begin
            res_n = {aln_q.sign_l, EXP_ONES, {MAN_W{1'b0}}};
            flg_n = 4'b0101;
        end

        result_d = (state_q == NORM) ? res_n : result_q;
        flags_d  = (state_q == NORM) ? flg_n : flags_q;
    end

    // State and datapath registers; reset clears everything and aborts any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            aln_q     <= '0;
            spc_q     <= '0;
            sum_q     <= '0;
            eff_sub_q <= 1'b0;
            result_q  <= '0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            aln_q     <= aln_d;
            spc_q     <= spc_d;
            sum_q     <= sum_d;
            eff_sub_q <= eff_sub_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
        end
    end

endmodule
